yarp_mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the YARP core. It fetches one instruction at a time from instruction memory and holds it stable for the combinational decode unit. It then steps the datapath through execute, data-memory access and write-back, using the decoder's instruction-type flags. It owns the PC, the retire counter and a sticky fault state.

---
 rtl/yarp_mc_ctrl_if.sv | 48 ++++
 rtl/yarp_mc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_yarp_mc_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/yarp_mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : yarp_mc_ctrl_if
// Brief    : Fetch, decode, data-memory and status bundle of the YARP controller
// Revision : 1.0 - initial release
// ============================================================================
interface yarp_mc_ctrl_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_o;
   logic [6:0]  op_i;
   logic        r_type_i;
   logic        i_type_i;
   logic        s_type_i;
   logic        b_type_i;
   logic        u_type_i;
   logic        j_type_i;
   logic        branch_taken_i;
   logic [31:0] next_pc_i;
   logic        dmem_req_o;
   logic        dmem_wr_o;
   logic        dmem_rvalid_i;
   logic        rf_wr_en_o;
   logic [31:0] pc_o;
   logic        retire_o;
   logic [31:0] instret_o;
   logic        halted_o;
   logic [1:0]  err_code_o;

   modport master (
      output imem_req_o, imem_addr_o, instr_o, dmem_req_o, dmem_wr_o,
             rf_wr_en_o, pc_o, retire_o, instret_o, halted_o, err_code_o,
      input  imem_rvalid_i, imem_rdata_i, op_i, r_type_i, i_type_i, s_type_i,
             b_type_i, u_type_i, j_type_i, branch_taken_i, next_pc_i,
             dmem_rvalid_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_o, dmem_req_o, dmem_wr_o,
             rf_wr_en_o, pc_o, retire_o, instret_o, halted_o, err_code_o,
      output imem_rvalid_i, imem_rdata_i, op_i, r_type_i, i_type_i, s_type_i,
             b_type_i, u_type_i, j_type_i, branch_taken_i, next_pc_i,
             dmem_rvalid_i
   );
endinterface
`default_nettype wire

// File: rtl/yarp_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : yarp_mc_ctrl
// Brief    : Multi-cycle fetch/execute/memory/write-back sequencer for YARP
// Revision : 1.0 - initial release
// ============================================================================
module yarp_mc_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           reset,
   yarp_mc_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_WAIT_I = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WAIT_D = 3'd5,
      S_WB     = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   localparam logic [15:0] c_timeout     = 16'(MEM_TIMEOUT);
   localparam logic [6:0]  c_op_load     = 7'h03;
   localparam logic [6:0]  c_op_jalr     = 7'h67;
   localparam logic [1:0]  c_err_illegal = 2'd1;
   localparam logic [1:0]  c_err_timeout = 2'd2;
   localparam logic [1:0]  c_err_align   = 2'd3;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instret;
   logic [15:0] r_wait_cnt;
   logic [1:0]  r_err_code;
   logic        r_halted;
   logic        r_imem_req;
   logic        r_dmem_req;
   logic        r_dmem_wr;
   logic        r_rf_wr_en;
   logic        r_retire;

   logic        w_any_type;
   logic        w_is_mem;
   logic        w_writes_rf;
   logic        w_redirect;
   logic        w_misaligned;

   // Decode flags come from the latched instruction, so they are stable
   // from DECODE onward and safe to use for registering the strobes.
   assign w_any_type   = bus.r_type_i | bus.i_type_i | bus.s_type_i |
                         bus.b_type_i | bus.u_type_i | bus.j_type_i;
   assign w_is_mem     = bus.s_type_i | (bus.op_i == c_op_load);
   assign w_writes_rf  = bus.r_type_i | bus.i_type_i | bus.u_type_i | bus.j_type_i;
   assign w_redirect   = bus.j_type_i | (bus.op_i == c_op_jalr) |
                         (bus.b_type_i & bus.branch_taken_i);
   assign w_misaligned = w_redirect & (bus.next_pc_i[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_pc       <= RESET_PC;
         r_instr    <= 32'h0;
         r_instret  <= 32'h0;
         r_wait_cnt <= 16'h0;
         r_err_code <= 2'd0;
         r_halted   <= 1'b0;
         r_imem_req <= 1'b1;
         r_dmem_req <= 1'b0;
         r_dmem_wr  <= 1'b0;
         r_rf_wr_en <= 1'b0;
         r_retire   <= 1'b0;
      end else begin
         r_imem_req <= 1'b0;
         r_dmem_req <= 1'b0;
         r_dmem_wr  <= 1'b0;
         r_rf_wr_en <= 1'b0;
         r_retire   <= 1'b0;
         case (r_state)
            S_FETCH: begin
               r_wait_cnt <= 16'h0;
               r_state    <= S_WAIT_I;
            end
            S_WAIT_I: begin
               if (bus.imem_rvalid_i) begin
                  r_instr <= bus.imem_rdata_i;
                  r_state <= S_DECODE;
               end else if (r_wait_cnt == c_timeout) begin
                  r_err_code <= c_err_timeout;
                  r_halted   <= 1'b1;
                  r_state    <= S_ERROR;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            S_DECODE: begin
               if (!w_any_type) begin
                  r_err_code <= c_err_illegal;
                  r_halted   <= 1'b1;
                  r_state    <= S_ERROR;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_is_mem) begin
                  r_dmem_req <= 1'b1;
                  r_dmem_wr  <= bus.s_type_i;
                  r_state    <= S_MEM;
               end else if (w_misaligned) begin
                  // Faulting here keeps WB from ever pulsing rf_wr_en/retire.
                  r_err_code <= c_err_align;
                  r_halted   <= 1'b1;
                  r_state    <= S_ERROR;
               end else begin
                  r_rf_wr_en <= w_writes_rf;
                  r_retire   <= 1'b1;
                  r_state    <= S_WB;
               end
            end
            S_MEM: begin
               r_wait_cnt <= 16'h0;
               r_state    <= S_WAIT_D;
            end
            S_WAIT_D: begin
               if (bus.dmem_rvalid_i) begin
                  r_rf_wr_en <= w_writes_rf;
                  r_retire   <= 1'b1;
                  r_state    <= S_WB;
               end else if (r_wait_cnt == c_timeout) begin
                  r_err_code <= c_err_timeout;
                  r_halted   <= 1'b1;
                  r_state    <= S_ERROR;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            S_WB: begin
               r_pc       <= w_redirect ? bus.next_pc_i : (r_pc + 32'd4);
               r_instret  <= r_instret + 32'd1;
               r_imem_req <= 1'b1;
               r_state    <= S_FETCH;
            end
            S_ERROR: begin
               r_state <= S_ERROR;
            end
            default: begin
               r_halted <= 1'b1;
               r_state  <= S_ERROR;
            end
         endcase
      end
   end

   assign bus.imem_req_o  = r_imem_req;
   assign bus.imem_addr_o = r_pc;
   assign bus.instr_o     = r_instr;
   assign bus.dmem_req_o  = r_dmem_req;
   assign bus.dmem_wr_o   = r_dmem_wr;
   assign bus.rf_wr_en_o  = r_rf_wr_en;
   assign bus.pc_o        = r_pc;
   assign bus.retire_o    = r_retire;
   assign bus.instret_o   = r_instret;
   assign bus.halted_o    = r_halted;
   assign bus.err_code_o  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_yarp_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_yarp_mc_ctrl
// Brief    : Directed scoreboard bench for yarp_mc_ctrl with a small decoder
// Revision : 1.0 - initial release
// ============================================================================
module tb_yarp_mc_ctrl;

   localparam logic [31:0] c_reset_pc = 32'h0000_1000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   yarp_mc_ctrl_if bus();

   yarp_mc_ctrl #(
      .RESET_PC    (c_reset_pc),
      .MEM_TIMEOUT (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stand-in for the combinational decode unit.
   always_comb begin
      bus.op_i     = bus.instr_o[6:0];
      bus.r_type_i = (bus.instr_o[6:0] == 7'h33);
      bus.i_type_i = (bus.instr_o[6:0] == 7'h13) || (bus.instr_o[6:0] == 7'h03) ||
                     (bus.instr_o[6:0] == 7'h67);
      bus.s_type_i = (bus.instr_o[6:0] == 7'h23);
      bus.b_type_i = (bus.instr_o[6:0] == 7'h63);
      bus.u_type_i = (bus.instr_o[6:0] == 7'h37) || (bus.instr_o[6:0] == 7'h17);
      bus.j_type_i = (bus.instr_o[6:0] == 7'h6F);
   end

   typedef struct {
      string       nm;
      logic [31:0] instr;
      logic [31:0] cyc;
      logic [31:0] nrf;
      logic [31:0] nd;
      logic        dwr;
      logic [31:0] pc;
      logic [31:0] ret;
      logic [1:0]  err;
   } exp_t;

   exp_t expq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // which: 0 = imem_req_o, 1 = dmem_req_o, 2 = halted_o
   task automatic wait_evt(input int which, input string nm);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(negedge clk);
         case (which)
            0:       hit = bus.imem_req_o;
            1:       hit = bus.dmem_req_o;
            default: hit = bus.halted_o;
         endcase
      end
      chk({nm, "_wait_event"}, {31'b0, hit}, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // iwait/dwait: extra wait cycles before rvalid; iwait < 0 never responds.
   task automatic run(input string nm, input logic [31:0] instr, input logic taken,
                      input logic [31:0] tgt, input int iwait, input int dwait,
                      input logic [31:0] cyc, input logic rf, input logic [31:0] nd,
                      input logic dwr, input logic [31:0] pc, input logic [31:0] ret,
                      input logic [1:0] err);
      exp_t e;
      e.nm = nm; e.instr = instr; e.cyc = cyc; e.nrf = {31'b0, rf}; e.nd = nd;
      e.dwr = dwr; e.pc = pc; e.ret = ret; e.err = err;
      expq.push_back(e);
      wait_evt(0, nm);
      bus.branch_taken_i = taken;
      bus.next_pc_i      = tgt;
      if (iwait < 0) begin
         wait_evt(2, nm);
         return;
      end
      @(posedge clk); #1;
      repeat (iwait) begin @(posedge clk); #1; end
      bus.imem_rdata_i  = instr;
      bus.imem_rvalid_i = 1'b1;
      @(posedge clk); #1;
      bus.imem_rvalid_i = 1'b0;
      if (nd != 0) begin
         wait_evt(1, nm);
         @(posedge clk); #1;
         repeat (dwait) begin @(posedge clk); #1; end
         bus.dmem_rvalid_i = 1'b1;
         @(posedge clk); #1;
         bus.dmem_rvalid_i = 1'b0;
      end
      if (err != 2'd0) wait_evt(2, nm);
   endtask

   // Monitor: one record per instruction, closed at the next fetch or at a fault.
   logic        m_busy = 1'b0;
   logic        m_halt_seen = 1'b0;
   logic [31:0] m_cyc, m_nrf, m_nret, m_nd, m_instr;
   logic        m_dwr;
   exp_t        me;

   always @(negedge clk) begin
      if (reset) begin
         m_busy      = 1'b0;
         m_halt_seen = 1'b0;
      end else begin
         if (bus.imem_req_o || (bus.halted_o && !m_halt_seen)) begin
            if (m_busy) begin
               if (expq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_completion: got pc %h expected no instruction", bus.pc_o);
               end else begin
                  me = expq.pop_front();
                  chk({me.nm, "_cycles"},  m_cyc, me.cyc);
                  chk({me.nm, "_rf_wr"},   m_nrf, me.nrf);
                  chk({me.nm, "_retire"},  m_nret, (me.err == 2'd0) ? 32'd1 : 32'd0);
                  chk({me.nm, "_dmem_req"}, m_nd, me.nd);
                  if (me.nd != 0) chk({me.nm, "_dmem_wr"}, {31'b0, m_dwr}, {31'b0, me.dwr});
                  if (me.err == 2'd0) chk({me.nm, "_instr"}, m_instr, me.instr);
                  chk({me.nm, "_pc"},      bus.pc_o, me.pc);
                  chk({me.nm, "_instret"}, bus.instret_o, me.ret);
                  chk({me.nm, "_err"},     {30'b0, bus.err_code_o}, {30'b0, me.err});
                  chk({me.nm, "_halted"},  {31'b0, bus.halted_o}, (me.err != 2'd0) ? 32'd1 : 32'd0);
               end
            end
            m_busy      = bus.imem_req_o;
            m_halt_seen = bus.halted_o;
            m_cyc = 0; m_nrf = 0; m_nret = 0; m_nd = 0; m_dwr = 1'b0; m_instr = 0;
         end
         if (m_busy) begin
            m_cyc++;
            if (bus.rf_wr_en_o) m_nrf++;
            if (bus.retire_o) begin m_nret++; m_instr = bus.instr_o; end
            if (bus.dmem_req_o) begin m_nd++; m_dwr = bus.dmem_wr_o; end
         end
      end
   end

   initial begin
      bus.imem_rvalid_i  = 1'b0;
      bus.imem_rdata_i   = 32'h0;
      bus.dmem_rvalid_i  = 1'b1;   // stale response present across reset
      bus.branch_taken_i = 1'b0;
      bus.next_pc_i      = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc",       bus.pc_o, c_reset_pc);
      chk("rst_addr",     bus.imem_addr_o, c_reset_pc);
      chk("rst_instr",    bus.instr_o, 32'h0);
      chk("rst_instret",  bus.instret_o, 32'h0);
      chk("rst_err",      {30'b0, bus.err_code_o}, 32'h0);
      chk("rst_halted",   {31'b0, bus.halted_o}, 32'h0);
      chk("rst_imem_req", {31'b0, bus.imem_req_o}, 32'h1);
      chk("rst_strobes",  {29'b0, bus.dmem_req_o, bus.rf_wr_en_o, bus.retire_o}, 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      bus.dmem_rvalid_i = 1'b0;

      //   name     instr         tk  target        iw dw cyc rf nd wr pc            ret  err
      run("addi",   32'h00500093, 0, 32'h0,        0, 0, 5,  1, 0, 0, 32'h0000_1004, 1,  0);
      run("lw",     32'h0000A103, 0, 32'h0,        0, 3, 10, 1, 1, 0, 32'h0000_1008, 2,  0);
      run("sw",     32'h0020A023, 0, 32'h0,        1, 0, 8,  0, 1, 1, 32'h0000_100C, 3,  0);
      run("beq_t",  32'h00000063, 1, 32'h40,       0, 0, 5,  0, 0, 0, 32'h0000_0040, 4,  0);
      run("beq_nt", 32'h00000063, 0, 32'h80,       0, 0, 5,  0, 0, 0, 32'h0000_0044, 5,  0);
      run("jal",    32'h0000006F, 0, 32'h100,      0, 0, 5,  1, 0, 0, 32'h0000_0100, 6,  0);
      run("jalr",   32'h00008067, 0, 32'h200,      0, 0, 5,  1, 0, 0, 32'h0000_0200, 7,  0);
      run("lui",    32'h123450B7, 0, 32'h0,        0, 0, 5,  1, 0, 0, 32'h0000_0204, 8,  0);
      run("add_w3", 32'h002081B3, 0, 32'h0,        3, 0, 8,  1, 0, 0, 32'h0000_0208, 9,  0);
      run("addi_u", 32'h00500093, 0, 32'h102,      0, 0, 5,  1, 0, 0, 32'h0000_020C, 10, 0);
      run("jal_mis",32'h0000006F, 0, 32'h102,      0, 0, 4,  0, 0, 0, 32'h0000_020C, 10, 3);

      // ERROR must hold and ignore responses until reset.
      repeat (4) @(posedge clk);
      #1 bus.imem_rvalid_i = 1'b1; bus.dmem_rvalid_i = 1'b1;
      @(posedge clk); #1 bus.imem_rvalid_i = 1'b0; bus.dmem_rvalid_i = 1'b0;
      @(negedge clk);
      chk("err_sticky_halted",  {31'b0, bus.halted_o}, 32'h1);
      chk("err_sticky_code",    {30'b0, bus.err_code_o}, 32'h3);
      chk("err_sticky_strobes", {28'b0, bus.imem_req_o, bus.dmem_req_o, bus.rf_wr_en_o, bus.retire_o}, 32'h0);
      chk("err_sticky_pc",      bus.pc_o, 32'h0000_020C);

      do_reset();
      run("illegal", 32'h0000007F, 0, 32'h0,       0, 0, 3,  0, 0, 0, c_reset_pc,    0,  1);
      do_reset();
      run("timeout", 32'h00500093, 0, 32'h0,      -1, 0, 5,  0, 0, 0, c_reset_pc,    0,  2);
      do_reset();

      // Reset mid-load, with a stale data response afterwards.
      run("addi_pre", 32'h00500093, 0, 32'h0,      0, 0, 5,  1, 0, 0, 32'h0000_1004, 1,  0);
      wait_evt(0, "lw_abort");
      @(posedge clk); #1;
      bus.imem_rdata_i = 32'h0000A103; bus.imem_rvalid_i = 1'b1;
      @(posedge clk); #1 bus.imem_rvalid_i = 1'b0;
      wait_evt(1, "lw_abort");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_pc",       bus.pc_o, c_reset_pc);
      chk("mid_rst_instret",  bus.instret_o, 32'h0);
      chk("mid_rst_strobes",  {30'b0, bus.rf_wr_en_o, bus.retire_o}, 32'h0);
      chk("mid_rst_imem_req", {31'b0, bus.imem_req_o}, 32'h1);
      bus.dmem_rvalid_i = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      run("addi_post", 32'h00500093, 0, 32'h0,     0, 0, 5,  1, 0, 0, 32'h0000_1004, 1,  0);
      bus.dmem_rvalid_i = 1'b0;

      wait_evt(0, "final_fetch");
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", expq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
